alu_share_arbiter: RTL

//  Shares the single combinational ALU datapath (arithmetic/logic/comparison/magic,
//  10-bit result) between two requesters. Latches the winning request's MODE/OP/IN,

---
 rtl/alu_ctrl_pkg.sv | 19 +
 rtl/arb2_rr.sv | 37 +++
 rtl/alu_share_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU share arbiter: FSM state encoding,
// ALU mode constants and default bus widths.
package alu_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ARITH = 2'd0;
  localparam logic [1:0] MODE_LOGIC = 2'd1;
  localparam logic [1:0] MODE_COMP  = 2'd2;
  localparam logic [1:0] MODE_MAGIC = 2'd3;

endpackage

// File: rtl/arb2_rr.sv
// Two-way arbiter: request vector plus priority pointer -> one-hot grant.
// Build option: ROUND_ROBIN_EN selects pointer-based tie breaking;
// without it requester 0 always wins a tie and the pointer is ignored.
module arb2_rr
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

`ifdef ROUND_ROBIN_EN
  // Tie goes to the requester the pointer favours; single requests pass straight through.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = i_ptr ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;

  // Fixed priority: requester 0 first.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[0]) begin
      o_gnt = 2'b01;
    end else if (i_req[1]) begin
      o_gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. The winning request's
// MODE/OP/IN are latched at the IDLE edge, held for one EXEC cycle, and the ALU
// result is captured and returned with a one-cycle DONE pulse.
// Build option: ROUND_ROBIN_EN (handled in arb2_rr) enables alternating priority.
//
//  state   | meaning
//  ST_IDLE | no owner; waits for a request, latches winner's operands
//  ST_EXEC | ALU driven from latched operands; result captured at edge
//  ST_DONE | DONE pulse to owner; grant released, pointer advanced
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = alu_ctrl_pkg::DATA_W,
  parameter int RES_W  = alu_ctrl_pkg::RES_W
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_mode0,
  input  logic [1:0]        i_mode1,
  input  logic [1:0]        i_op0,
  input  logic [1:0]        i_op1,
  input  logic [DATA_W-1:0] i_in0,
  input  logic [DATA_W-1:0] i_in1,
  output logic [1:0]        o_alu_mode,
  output logic [1:0]        o_alu_op,
  output logic [DATA_W-1:0] o_alu_in,
  input  logic [RES_W-1:0]  i_alu_f,
  output logic [1:0]        o_gnt,
  output logic              o_busy,
  output logic [1:0]        o_done,
  output logic [RES_W-1:0]  o_result
);

  state_t              r_state;
  logic                r_ptr;
  logic [1:0]          r_alu_mode;
  logic [1:0]          r_alu_op;
  logic [DATA_W-1:0]   r_alu_in;
  logic [1:0]          r_gnt;
  logic                r_busy;
  logic [1:0]          r_done;
  logic [RES_W-1:0]    r_result;
  logic [1:0]          w_gnt;

  arb2_rr u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // Sequencing FSM with registered ALU operands, grant, busy, done and result.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      r_alu_mode <= '0;
      r_alu_op   <= '0;
      r_alu_in   <= '0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req != 2'b00) begin
            r_alu_mode <= w_gnt[1] ? i_mode1 : i_mode0;
            r_alu_op   <= w_gnt[1] ? i_op1   : i_op0;
            r_alu_in   <= w_gnt[1] ? i_in1   : i_in0;
            r_gnt      <= w_gnt;
            r_busy     <= 1'b1;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result <= i_alu_f;
          r_done   <= r_gnt;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          // Pointer moves to the requester that was not just served.
          r_ptr   <= r_gnt[0];
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_alu_mode = r_alu_mode;
  assign o_alu_op   = r_alu_op;
  assign o_alu_in   = r_alu_in;
  assign o_gnt      = r_gnt;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_result   = r_result;

endmodule
